// File: rtl/spi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_pkg
// Purpose  : Shared definitions for the SPI mode-0 target.
//            This file holds the idle line levels for SPI mode 0 (CPOL=0).
//            It also holds the default configuration values and the
//            target FSM state encoding.
// Ports    : none (package)
// Macro    : SPI_TARGET_OVR_EN (used by spi_target, not here)
// Revision : 1.0 - initial release
// ============================================================================
package spi_target_pkg;

  // Mode 0: sclk idles low; chip select is active-low and idles high.
  localparam logic C_SCLK_IDLE       = 1'b0;
  localparam logic C_CS_N_IDLE       = 1'b1;

  localparam int   C_DATA_W_DEF      = 8;
  localparam int   C_SYNC_STAGES_DEF = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage : spi_target_pkg
`default_nettype wire

// File: rtl/spi_target_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-flop synchronizer for one asynchronous pin.
//            It produces single-cycle rise and fall pulses.
//            The pulses come from comparing the synchronized level with
//            its value one clock earlier.
// Ports    : clk      in  system clock
//            rst      in  asynchronous reset, active-high
//            i_async  in  asynchronous pin
//            o_rise   out one-cycle pulse on a synchronized 0->1 transition
//            o_fall   out one-cycle pulse on a synchronized 1->0 transition
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync;

  // Reset to the pin's idle level so that leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = w_sync & ~r_prev;
  assign o_fall = ~w_sync & r_prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Purpose  : SPI mode-0 responder oversampling sclk/cs_n/mosi in clk domain.
//            Receives words MSB-first on sclk rise and transmits reply words
//            MSB-first on sclk fall.
//            Received words go out on a valid/ready interface.
//            Reply words come in on valid/ready into a one-entry buffer.
// Ports    : clk, rst             system clock, async active-high reset
//            sclk, cs_n, mosi     SPI pins from the master (asynchronous)
//            miso, miso_oe        target data out and its output enable
//            rx_data/valid/ready  received word stream
//            tx_data/valid/ready  reply word stream (ready = buffer empty)
//            busy                 high while selected
//            overrun, ovr_clr     sticky overwrite flag and its clear
// Macro    : SPI_TARGET_OVR_EN - adds the overrun/ovr_clr ports; without it
//            an unread word is overwritten silently.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target
  import spi_target_pkg::*;
#(
  parameter int DATA_W      = C_DATA_W_DEF,
  parameter int SYNC_STAGES = C_SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy
`ifdef SPI_TARGET_OVR_EN
  ,
  output logic              overrun,
  input  logic              ovr_clr
`endif
);

  localparam int              CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_W - 1);

  // ---------------- synchronizers ----------------
  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(C_SCLK_IDLE)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .i_async(sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(C_CS_N_IDLE)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .i_async(cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // mosi needs the same latency as the sclk path so the sample lines up
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // ---------------- FSM ----------------
  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [DATA_W-2:0]   r_rx_shift;   // only the first DATA_W-1 bits need storing
  logic [DATA_W-1:0]   r_tx_shift;
  logic [DATA_W-1:0]   r_tx_buf;
  logic                r_tx_full;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;

  logic w_start, w_abort, w_rx_edge, w_tx_edge;
  logic w_miso, w_miso_oe, w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // cs_n release is checked first so it wins over a coincident sclk edge.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_rx_edge   = 1'b0;
    w_tx_edge   = 1'b0;
    w_miso      = 1'b0;
    w_miso_oe   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_start     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_miso_oe = 1'b1;
        w_busy    = 1'b1;
        w_miso    = r_tx_shift[DATA_W-1];
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_rx_edge = w_sclk_rise;
          w_tx_edge = w_sclk_fall;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  logic              w_word_done, w_tx_load, w_rx_accept;
  logic [DATA_W-1:0] w_rx_word;

  assign w_word_done = w_rx_edge && (r_bit_cnt == C_LAST_BIT);
  // Reload happens at select and on the sclk fall following a completed word.
  assign w_tx_load   = w_start || (w_tx_edge && (r_bit_cnt == '0));
  assign w_rx_accept = r_rx_valid && rx_ready;
  assign w_rx_word   = {r_rx_shift, w_mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_tx_buf   <= '0;
      r_tx_full  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_start || w_abort)  r_bit_cnt <= '0;
      else if (w_word_done)    r_bit_cnt <= '0;
      else if (w_rx_edge)      r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_rx_edge) r_rx_shift <= w_rx_word[DATA_W-2:0];

      if (w_word_done) begin
        r_rx_data  <= w_rx_word;
        r_rx_valid <= 1'b1;
      end else if (w_rx_accept) begin
        r_rx_valid <= 1'b0;
      end

      if (w_abort)        r_tx_shift <= '0;
      else if (w_tx_load) r_tx_shift <= r_tx_full ? r_tx_buf : '0;
      else if (w_tx_edge) r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};

      // A load only drains a full buffer and capture only fills an empty one,
      // so an empty-buffer load still lets a same-cycle offer be captured.
      if (w_tx_load && r_tx_full) begin
        r_tx_full <= 1'b0;
      end else if (tx_valid && !r_tx_full) begin
        r_tx_buf  <= tx_data;
        r_tx_full <= 1'b1;
      end
    end
  end

`ifdef SPI_TARGET_OVR_EN
  logic r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_overrun <= 1'b0;
    else if (w_word_done && r_rx_valid && !rx_ready) r_overrun <= 1'b1;
    else if (ovr_clr)                               r_overrun <= 1'b0;
  end
  assign overrun = r_overrun;
`endif

  assign miso     = w_miso;
  assign miso_oe  = w_miso_oe;
  assign busy     = w_busy;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_ready = ~r_tx_full;

endmodule : spi_target
`default_nettype wire

// File: tb/tb_spi_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Purpose  : Self-checking bench for spi_target.
//            A mode-0 master runs at clk/8. Expected rx and miso words come
//            from per-frame word lists: the words sent, and the words
//            offered to the reply buffer (or zero when none is offered).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       rx_ready = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, miso_oe, rx_valid, tx_ready, busy;
  logic [7:0] rx_data;
`ifdef SPI_TARGET_OVR_EN
  logic       overrun;
  logic       ovr_clr = 1'b0;
`endif

  spi_target #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy)
`ifdef SPI_TARGET_OVR_EN
    ,
    .overrun (overrun),
    .ovr_clr (ovr_clr)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] q_rx[$];
  logic [7:0] q_miso[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] f_mosi[4];
  logic [7:0] f_tx[4];
  bit         f_have[4];

  // Words accepted by the consumer, observed half a cycle before the accept edge.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) q_rx.push_back(rx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] v);
    @(negedge clk);
    chk("tx_ready_pre", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = v;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Expected results of a full frame: every word echoes back as rx; miso
  // carries the offered reply word or zero when none was offered.
  task automatic plan(input int nw);
    for (int k = 0; k < nw; k++) begin
      exp_rx.push_back(f_mosi[k]);
      exp_miso.push_back(f_have[k] ? f_tx[k] : 8'h00);
    end
  endtask

  task automatic compare(input string tag);
    logic [7:0] e;
    chk({tag, "_rxcnt"}, 32'(q_rx.size()), 32'(exp_rx.size()));
    chk({tag, "_misocnt"}, 32'(q_miso.size()), 32'(exp_miso.size()));
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      if (q_rx.size() > 0) chk({tag, "_rx"}, 32'(q_rx.pop_front()), 32'(e));
    end
    while (exp_miso.size() > 0) begin
      e = exp_miso.pop_front();
      if (q_miso.size() > 0) chk({tag, "_miso"}, 32'(q_miso.pop_front()), 32'(e));
    end
    q_rx.delete();
    q_miso.delete();
  endtask

  // Mode-0 master: mosi set on the falling half, sclk high for 4 clk, low for 4 clk.
  // cut>0 stops after that many bits (cs release, or reset if do_rst).
  task automatic spi_frame(input int nw, input int cut, input bit do_rst);
    logic [7:0] m;
    int         nbits;
    bit         stop;
    nbits = 0;
    stop  = 1'b0;
    if (f_have[0]) tx_write(f_tx[0]);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("active_flags", 32'({busy, miso_oe}), 32'd3);
    for (int w = 0; w < nw && !stop; w++) begin
      m = 8'h00;
      for (int b = 7; b >= 0 && !stop; b--) begin
        if (cut > 0 && nbits == cut) begin
          stop = 1'b1;
        end else begin
          mosi = f_mosi[w][b];
          if (b == 5 && w + 1 < nw && f_have[w+1]) begin
            chk("tx_ready_mid", 32'(tx_ready), 32'd1);
            tx_valid = 1'b1;
            tx_data  = f_tx[w+1];
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (3) @(negedge clk);
          end else begin
            repeat (4) @(negedge clk);
          end
          m[b] = miso;
          sclk = 1'b1;
          repeat (4) @(negedge clk);
          sclk = 1'b0;
          nbits++;
        end
      end
      if (!stop) q_miso.push_back(m);
    end
    if (stop && do_rst) begin
      chk("pre_rst_tx_ready", 32'(tx_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_flags", 32'({miso, miso_oe, rx_valid, tx_ready, busy}), 32'b00010);
      chk("rst_async_rx_data", 32'(rx_data), 32'd0);
`ifdef SPI_TARGET_OVR_EN
      chk("rst_async_overrun", 32'(overrun), 32'd0);
`endif
      sclk = 1'b0;
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_flags", 32'({miso, miso_oe, rx_valid, tx_ready, busy}), 32'b00010);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
`ifdef SPI_TARGET_OVR_EN
    chk("reset_overrun", 32'(overrun), 32'd0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single word, reply buffered
    f_mosi[0] = 8'hA5; f_tx[0] = 8'h3C; f_have[0] = 1'b1;
    plan(1);
    spi_frame(1, 0, 1'b0);
    compare("t1");
    chk("t1_idle", 32'({busy, miso_oe, miso}), 32'd0);

    // two words under one select, second reply written after first load
    f_mosi[0] = 8'h01; f_mosi[1] = 8'h80;
    f_tx[0] = 8'h11; f_tx[1] = 8'h22; f_have[0] = 1'b1; f_have[1] = 1'b1;
    plan(2);
    spi_frame(2, 0, 1'b0);
    compare("t2");

    // empty reply buffer
    f_mosi[0] = 8'h5C; f_have[0] = 1'b0;
    plan(1);
    spi_frame(1, 0, 1'b0);
    compare("t3");
    chk("t3_tx_ready", 32'(tx_ready), 32'd1);

    // abort after 5 bits, then a clean frame
    f_mosi[0] = 8'hFF; f_have[0] = 1'b0;
    spi_frame(1, 5, 1'b0);
    chk("t4_no_rx", 32'(q_rx.size()), 32'd0);
    chk("t4_flags", 32'({busy, rx_valid}), 32'd0);
    q_miso.delete();
    f_mosi[0] = 8'h42;
    plan(1);
    spi_frame(1, 0, 1'b0);
    compare("t4");

    // consumer stalled across two words
    @(posedge clk); #1 rx_ready = 1'b0;
    f_mosi[0] = 8'h10; f_mosi[1] = 8'h20; f_have[0] = 1'b0; f_have[1] = 1'b0;
    spi_frame(2, 0, 1'b0);
    chk("t5_rx_valid", 32'(rx_valid), 32'd1);
    chk("t5_rx_data", 32'(rx_data), 32'h20);
    chk("t5_no_accept", 32'(q_rx.size()), 32'd0);
`ifdef SPI_TARGET_OVR_EN
    repeat (5) @(negedge clk);
    chk("t5_overrun_set", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("t5_overrun_clr", 32'(overrun), 32'd0);
`endif
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    exp_rx.push_back(8'h20);
    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h00);
    compare("t5");

    // reset mid-frame after 3 bits, then a clean frame
    f_mosi[0] = 8'hE7; f_mosi[1] = 8'h81;
    f_tx[0] = 8'h99; f_tx[1] = 8'h66; f_have[0] = 1'b1; f_have[1] = 1'b1;
    spi_frame(2, 3, 1'b1);
    chk("t6_no_rx", 32'(q_rx.size()), 32'd0);
    q_miso.delete();
    f_mosi[0] = 8'h5A; f_tx[0] = 8'hC3; f_have[0] = 1'b1;
    plan(1);
    spi_frame(1, 0, 1'b0);
    compare("t6");

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      int nw;
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++) begin
        f_mosi[k] = 8'($urandom);
        f_tx[k]   = 8'($urandom);
        f_have[k] = 1'($urandom_range(0, 1));
      end
      plan(nw);
      spi_frame(nw, 0, 1'b0);
      compare("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_spi_target
`default_nettype wire
